// File: rtl/control_sequencer_if.sv
// ============================================================================
// Module      : control_sequencer_if
// Description : Bundles the control_sequencer handshake and microcode bus.
//               The slave modport is the sequencer side and the master
//               modport is the fetch/ROM/datapath environment.
//               SEQ_SINGLE_STEP_EN adds the step_i single-step strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface control_sequencer_if #(
   parameter int OPCODE_W = 8,
   parameter int STEP_W   = 3,
   parameter int CW_W     = 25
);
   logic                       start_i;
   logic                       instr_valid_i;
   logic [OPCODE_W-1:0]        instr_i;
   logic                       instr_ready_o;
   logic [OPCODE_W+STEP_W-1:0] uaddr_o;
   logic [CW_W+2:0]            uword_i;
   logic [1:0]                 flags_i;
   logic                       mem_ready_i;
   logic [CW_W-1:0]            cw_o;
   logic                       cw_valid_o;
   logic                       halted_o;
   logic                       seq_err_o;
`ifdef SEQ_SINGLE_STEP_EN
   logic                       step_i;

   modport slave (
      input  start_i, instr_valid_i, instr_i, uword_i, flags_i, mem_ready_i, step_i,
      output instr_ready_o, uaddr_o, cw_o, cw_valid_o, halted_o, seq_err_o
   );

   modport master (
      output start_i, instr_valid_i, instr_i, uword_i, flags_i, mem_ready_i, step_i,
      input  instr_ready_o, uaddr_o, cw_o, cw_valid_o, halted_o, seq_err_o
   );
`else
   modport slave (
      input  start_i, instr_valid_i, instr_i, uword_i, flags_i, mem_ready_i,
      output instr_ready_o, uaddr_o, cw_o, cw_valid_o, halted_o, seq_err_o
   );

   modport master (
      output start_i, instr_valid_i, instr_i, uword_i, flags_i, mem_ready_i,
      input  instr_ready_o, uaddr_o, cw_o, cw_valid_o, halted_o, seq_err_o
   );
`endif
endinterface

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module      : control_sequencer
// Description : Microcode sequencer. Fetches an opcode over valid/ready,
//               walks {opcode, step} over an external combinational ROM,
//               gates each microword on ALU flags, stalls on memory and
//               halts on the control word's halt bit.
//               Optional feature macro: SEQ_SINGLE_STEP_EN (step_i strobe
//               gates microstep evaluation in EXEC).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
   parameter int OPCODE_W = 8,
   parameter int STEP_W   = 3,
   parameter int CW_W     = 25,
   parameter int NEXT_BIT = 0,
   parameter int HALT_BIT = 2
) (
   input  wire                 clk,
   input  wire                 rst_n,
   control_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [STEP_W-1:0] c_STEP_MAX = {STEP_W{1'b1}};

   state_t              r_state,    w_state_nxt;
   logic [OPCODE_W-1:0] r_opcode,   w_opcode_nxt;
   logic [STEP_W-1:0]   r_step,     w_step_nxt;
   logic [CW_W-1:0]     r_cw,       w_cw_nxt;
   logic                r_cw_valid, w_cw_valid_nxt;
   logic                r_halted,   w_halted_nxt;
   logic                r_seq_err,  w_seq_err_nxt;

   // Microword fields: {wait, cond[1:0], cw}
   logic                w_wait;
   logic [1:0]          w_cond;
   logic [CW_W-1:0]     w_cw;
   logic                w_zero;
   logic                w_carry;
   logic                w_cond_true;
   logic                w_step_en;
   logic                w_stall;
   logic [STEP_W-1:0]   w_uaddr_step;

   assign w_wait  = bus.uword_i[CW_W+2];
   assign w_cond  = bus.uword_i[CW_W+1:CW_W];
   assign w_cw    = bus.uword_i[CW_W-1:0];
   assign w_zero  = bus.flags_i[1];
   assign w_carry = bus.flags_i[0];

`ifdef SEQ_SINGLE_STEP_EN
   assign w_step_en = bus.step_i;
`else
   assign w_step_en = 1'b1;
`endif

   // A waiting step only stalls when it actually executes
   assign w_stall = w_wait && !bus.mem_ready_i;

   // Step field of the ROM address is forced to zero outside EXEC
   assign w_uaddr_step = (r_state == S_EXEC) ? r_step : {STEP_W{1'b0}};

   assign bus.uaddr_o       = {r_opcode, w_uaddr_step};
   assign bus.instr_ready_o = (r_state == S_FETCH);
   assign bus.cw_o          = r_cw;
   assign bus.cw_valid_o    = r_cw_valid;
   assign bus.halted_o      = r_halted;
   assign bus.seq_err_o     = r_seq_err;

   // Decode the branch condition against the ALU flags
   always_comb begin
      w_cond_true = 1'b1;
      case (w_cond)
         2'b00:   w_cond_true = 1'b1;
         2'b01:   w_cond_true = w_zero;
         2'b10:   w_cond_true = w_carry;
         2'b11:   w_cond_true = !w_zero;
         default: w_cond_true = 1'b1;
      endcase
   end

   // Next-state and next-output logic; control word defaults to idle (zero)
   always_comb begin
      w_state_nxt    = r_state;
      w_opcode_nxt   = r_opcode;
      w_step_nxt     = r_step;
      w_cw_nxt       = {CW_W{1'b0}};
      w_cw_valid_nxt = 1'b0;
      w_halted_nxt   = r_halted;
      w_seq_err_nxt  = r_seq_err;

      case (r_state)
         S_IDLE: begin
            if (bus.start_i) begin
               w_state_nxt = S_FETCH;
            end
         end

         S_FETCH: begin
            if (bus.instr_valid_i) begin
               w_opcode_nxt = bus.instr_i;
               w_step_nxt   = {STEP_W{1'b0}};
               w_state_nxt  = S_EXEC;
            end
         end

         S_EXEC: begin
            if (w_step_en) begin
               if (w_cond_true) begin
                  w_cw_nxt       = w_cw;
                  w_cw_valid_nxt = 1'b1;
                  if (w_stall) begin
                     // Re-issue the same step until memory completes
                     w_step_nxt = r_step;
                  end else if (w_cw[HALT_BIT]) begin
                     w_state_nxt  = S_HALT;
                     w_halted_nxt = 1'b1;
                     w_step_nxt   = {STEP_W{1'b0}};
                  end else if (w_cw[NEXT_BIT]) begin
                     w_state_nxt = S_FETCH;
                     w_step_nxt  = {STEP_W{1'b0}};
                  end else if (r_step == c_STEP_MAX) begin
                     w_state_nxt   = S_FETCH;
                     w_step_nxt    = {STEP_W{1'b0}};
                     w_seq_err_nxt = 1'b1;
                  end else begin
                     w_step_nxt = r_step + 1'b1;
                  end
               end else begin
                  // Skipped step: wait, next and halt bits are ignored
                  if (r_step == c_STEP_MAX) begin
                     w_state_nxt   = S_FETCH;
                     w_step_nxt    = {STEP_W{1'b0}};
                     w_seq_err_nxt = 1'b1;
                  end else begin
                     w_step_nxt = r_step + 1'b1;
                  end
               end
            end
         end

         S_HALT: begin
            if (bus.start_i) begin
               w_state_nxt  = S_FETCH;
               w_halted_nxt = 1'b0;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_opcode   <= {OPCODE_W{1'b0}};
         r_step     <= {STEP_W{1'b0}};
         r_cw       <= {CW_W{1'b0}};
         r_cw_valid <= 1'b0;
         r_halted   <= 1'b0;
         r_seq_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_opcode   <= w_opcode_nxt;
         r_step     <= w_step_nxt;
         r_cw       <= w_cw_nxt;
         r_cw_valid <= w_cw_valid_nxt;
         r_halted   <= w_halted_nxt;
         r_seq_err  <= w_seq_err_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. A cycle table
//               covers fetch, conditional skip and memory wait; short
//               hand-written sequences cover halt, step overflow, reset
//               mid-instruction and a skipped step at the last microstep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   control_sequencer_if #(.OPCODE_W(8), .STEP_W(3), .CW_W(25)) sif ();

   control_sequencer #(
      .OPCODE_W(8), .STEP_W(3), .CW_W(25), .NEXT_BIT(0), .HALT_BIT(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif.slave)
   );

   // Combinational microcode ROM: {wait, cond[1:0], cw}
   logic [27:0] rom [0:2047];
   assign sif.uword_i = rom[sif.uaddr_o];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        vl;
      logic [7:0]  ins;
      logic [1:0]  fl;
      logic        mr;
      logic [10:0] eu;
      logic [24:0] ecw;
      logic        ev;
      logic        er;
      logic        eh;
      logic        ee;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [27:0] mw(input logic w, input logic [1:0] c, input logic [24:0] cw);
      return {w, c, cw};
   endfunction

   function automatic vec_t v(input logic st, input logic vl, input logic [7:0] ins,
                              input logic [1:0] fl, input logic mr, input logic [10:0] eu,
                              input logic [24:0] ecw, input logic ev, input logic er,
                              input logic eh, input logic ee);
      vec_t r;
      r.st = st; r.vl = vl; r.ins = ins; r.fl = fl; r.mr = mr;
      r.eu = eu; r.ecw = ecw; r.ev = ev; r.er = er; r.eh = eh; r.ee = ee;
      return r;
   endfunction

   task automatic drv(input logic st, input logic vl, input logic [7:0] ins,
                      input logic [1:0] fl, input logic mr);
      @(negedge clk);
      sif.start_i       = st;
      sif.instr_valid_i = vl;
      sif.instr_i       = ins;
      sif.flags_i       = fl;
      sif.mem_ready_i   = mr;
      #1;
   endtask

   task automatic chk(input string nm, input logic [10:0] eu, input logic [24:0] ecw,
                      input logic ev, input logic er, input logic eh, input logic ee);
      n_checks++;
      if ({sif.uaddr_o, sif.cw_o, sif.cw_valid_o, sif.instr_ready_o, sif.halted_o, sif.seq_err_o}
          !== {eu, ecw, ev, er, eh, ee}) begin
         n_errors++;
         $display("FAIL %s: got uaddr=%h cw=%h v=%b rdy=%b halt=%b err=%b want uaddr=%h cw=%h v=%b rdy=%b halt=%b err=%b",
                  nm, sif.uaddr_o, sif.cw_o, sif.cw_valid_o, sif.instr_ready_o, sif.halted_o,
                  sif.seq_err_o, eu, ecw, ev, er, eh, ee);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;

      for (int i = 0; i < 2048; i++) rom[i] = 28'h0;
      // 0x12: basic three steps
      rom[11'h090] = mw(1'b0, 2'b00, 25'h000010);
      rom[11'h091] = mw(1'b0, 2'b00, 25'h000020);
      rom[11'h092] = mw(1'b0, 2'b00, 25'h000021);
      // 0x20: step 1 executes only if zero
      rom[11'h100] = mw(1'b0, 2'b00, 25'h000100);
      rom[11'h101] = mw(1'b0, 2'b01, 25'h000200);
      rom[11'h102] = mw(1'b0, 2'b00, 25'h000301);
      // 0x30: step 0 waits on memory
      rom[11'h180] = mw(1'b1, 2'b00, 25'h000400);
      rom[11'h181] = mw(1'b0, 2'b00, 25'h000501);
      // 0x40: halt on step 1
      rom[11'h200] = mw(1'b0, 2'b00, 25'h000800);
      rom[11'h201] = mw(1'b0, 2'b00, 25'h000004);
      // 0x50: eight steps, no next bit; 0x70: same but last step skipped
      for (int k = 0; k < 8; k++) begin
         rom[11'h280 + k] = mw(1'b0, 2'b00, 25'h001000 | (k << 4));
         rom[11'h380 + k] = mw(1'b0, 2'b00, 25'h003000 | (k << 4));
      end
      rom[11'h387] = mw(1'b0, 2'b01, 25'h003071);
      // 0x60: five steps, interrupted by reset
      for (int k = 0; k < 5; k++) rom[11'h300 + k] = mw(1'b0, 2'b00, 25'h002000 | (k << 4));
      rom[11'h304] = mw(1'b0, 2'b00, 25'h002041);

      //             st vl ins    fl    mr  | uaddr   cw          v  rdy h  err
      tbl.push_back(v(1, 0, 8'h00, 2'b00, 1, 11'h000, 25'h000000, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 8'h12, 2'b00, 1, 11'h000, 25'h000000, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b00, 1, 11'h090, 25'h000000, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 8'h00, 2'b00, 1, 11'h091, 25'h000010, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b00, 1, 11'h092, 25'h000020, 1, 0, 0, 0));
      tbl.push_back(v(0, 1, 8'h20, 2'b00, 1, 11'h090, 25'h000021, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b00, 1, 11'h100, 25'h000000, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b00, 1, 11'h101, 25'h000100, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b00, 1, 11'h102, 25'h000000, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 8'h20, 2'b10, 1, 11'h100, 25'h000301, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b10, 1, 11'h100, 25'h000000, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b10, 1, 11'h101, 25'h000100, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b00, 1, 11'h102, 25'h000200, 1, 0, 0, 0));
      tbl.push_back(v(1, 1, 8'h30, 2'b00, 1, 11'h100, 25'h000301, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b00, 0, 11'h180, 25'h000000, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b00, 0, 11'h180, 25'h000400, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b00, 0, 11'h180, 25'h000400, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b00, 1, 11'h180, 25'h000400, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b00, 1, 11'h181, 25'h000400, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 2'b00, 1, 11'h180, 25'h000501, 1, 1, 0, 0));

      rst_n             = 1'b0;
      sif.start_i       = 1'b0;
      sif.instr_valid_i = 1'b0;
      sif.instr_i       = 8'h00;
      sif.flags_i       = 2'b00;
      sif.mem_ready_i   = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
      sif.step_i        = 1'b1;
`endif
      repeat (3) @(negedge clk);
      #1;
      chk("reset", 11'h000, 25'h0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fetch, conditional skip and memory wait
      foreach (tbl[i]) begin
         drv(tbl[i].st, tbl[i].vl, tbl[i].ins, tbl[i].fl, tbl[i].mr);
         chk($sformatf("vec%0d", i), tbl[i].eu, tbl[i].ecw, tbl[i].ev, tbl[i].er, tbl[i].eh, tbl[i].ee);
      end

      // Halt: halt-bit word shown for one cycle, then restart via start_i
      drv(0, 1, 8'h40, 2'b00, 1); chk("halt_fetch",   11'h180, 25'h0,      0, 1, 0, 0);
      drv(0, 0, 8'h00, 2'b00, 1); chk("halt_s0",      11'h200, 25'h0,      0, 0, 0, 0);
      drv(0, 0, 8'h00, 2'b00, 1); chk("halt_s1",      11'h201, 25'h000800, 1, 0, 0, 0);
      drv(0, 0, 8'h00, 2'b00, 1); chk("halt_cw",      11'h200, 25'h000004, 1, 0, 1, 0);
      drv(1, 0, 8'h00, 2'b00, 1); chk("halt_hold",    11'h200, 25'h0,      0, 0, 1, 0);
      drv(0, 0, 8'h00, 2'b00, 1); chk("halt_restart", 11'h200, 25'h0,      0, 1, 0, 0);

      // Overflow: eight steps without next bit
      drv(0, 1, 8'h50, 2'b00, 1); chk("ovf_fetch", 11'h200, 25'h0, 0, 1, 0, 0);
      drv(0, 0, 8'h00, 2'b00, 1); chk("ovf_s0",    11'h280, 25'h0, 0, 0, 0, 0);
      for (int k = 1; k < 8; k++) begin
         drv(0, 0, 8'h00, 2'b00, 1);
         chk($sformatf("ovf_s%0d", k), 11'h280 + 11'(k), 25'h001000 | 25'((k - 1) << 4), 1, 0, 0, 0);
      end
      drv(0, 1, 8'h12, 2'b00, 1); chk("ovf_err",   11'h280, 25'h001070, 1, 1, 0, 1);
      drv(0, 0, 8'h00, 2'b00, 1); chk("err_keep0", 11'h090, 25'h0,      0, 0, 0, 1);
      drv(0, 0, 8'h00, 2'b00, 1); chk("err_keep1", 11'h091, 25'h000010, 1, 0, 0, 1);
      drv(0, 0, 8'h00, 2'b00, 1); chk("err_keep2", 11'h092, 25'h000020, 1, 0, 0, 1);
      drv(0, 1, 8'h60, 2'b00, 1); chk("err_keep3", 11'h090, 25'h000021, 1, 1, 0, 1);

      // Reset for two cycles during step 2 drops the instruction
      drv(0, 0, 8'h00, 2'b00, 1); chk("rst_s0", 11'h300, 25'h0,      0, 0, 0, 1);
      drv(0, 0, 8'h00, 2'b00, 1); chk("rst_s1", 11'h301, 25'h002000, 1, 0, 0, 1);
      drv(0, 0, 8'h00, 2'b00, 1); chk("rst_s2", 11'h302, 25'h002010, 1, 0, 0, 1);
      rst_n = 1'b0;
      drv(0, 0, 8'h00, 2'b00, 1); chk("rst_a",  11'h000, 25'h0, 0, 0, 0, 0);
      drv(0, 0, 8'h00, 2'b00, 1); chk("rst_b",  11'h000, 25'h0, 0, 0, 0, 0);
      rst_n = 1'b1;
      drv(1, 0, 8'h00, 2'b00, 1); chk("rst_idle", 11'h000, 25'h0, 0, 0, 0, 0);

      // Skipped step at the last microstep also overflows
      drv(0, 1, 8'h70, 2'b00, 1); chk("skm_fetch", 11'h000, 25'h0, 0, 1, 0, 0);
      drv(0, 0, 8'h00, 2'b00, 1); chk("skm_s0",    11'h380, 25'h0, 0, 0, 0, 0);
      for (int k = 1; k < 8; k++) begin
         drv(0, 0, 8'h00, 2'b00, 1);
         chk($sformatf("skm_s%0d", k), 11'h380 + 11'(k), 25'h003000 | 25'((k - 1) << 4), 1, 0, 0, 0);
      end
      drv(0, 0, 8'h00, 2'b00, 1); chk("skm_err", 11'h380, 25'h0, 0, 1, 0, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
